// File: rtl/ipv4_vlg_rx_disp.sv
// Receive dispatcher: routes each IPv4 payload to the consumer whose protocol matches, drops unmatched packets.
// Latency: 1 cycle, all outputs registered. Optional statistics enabled by macro ETH_VLG_RX_DISP_STATS_EN.
// Backpressure: none; one byte accepted every cycle, sof mid-packet aborts the packet in flight.
module ipv4_vlg_rx_disp #(
    parameter int                  N     = 3,
    parameter int                  W     = 32,
    parameter logic [N-1:0][7:0]   PROTO = {8'd6, 8'd17, 8'd1}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           proto_in,
    input  logic [W-1:0]         meta_in,
    input  logic [7:0]           dat_in,
    input  logic                 val_in,
    input  logic                 sof_in,
    input  logic                 eof_in,
    input  logic                 err_in,
    output logic [N-1:0][W-1:0]  meta,
    output logic [7:0]           dat,
    output logic [N-1:0]         val,
    output logic [N-1:0]         sof,
    output logic [N-1:0]         eof,
    output logic [N-1:0]         err,
    output logic [N-1:0]         abt,
    output logic                 busy,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          abt_cnt
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t         state, state_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [SW-1:0]  idx;
    logic           hit;
    logic [N-1:0]   val_d, sof_d, eof_d, err_d, abt_d;
    logic           load_meta;
    logic           drop_inc;

    // Protocol lookup; the lowest matching table index wins on duplicates.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!hit && proto_in == PROTO[i]) begin
                hit = 1'b1;
                idx = SW'(i);
            end
        end
    end

    // Next-state and next-output decode; a sof is always evaluated as a fresh packet, aborting any in flight.
    always_comb begin
        state_d   = state;
        sel_d     = sel_q;
        val_d     = '0;
        sof_d     = '0;
        eof_d     = '0;
        err_d     = '0;
        abt_d     = '0;
        load_meta = 1'b0;
        drop_inc  = 1'b0;
        if (val_in) begin
            if (sof_in) begin
                if (state == FWD) begin
                    abt_d[sel_q] = 1'b1;
                end
                if (hit && !err_in) begin
                    sel_d       = idx;
                    val_d[idx]  = 1'b1;
                    sof_d[idx]  = 1'b1;
                    eof_d[idx]  = eof_in;
                    load_meta   = 1'b1;
                    state_d     = eof_in ? IDLE : FWD;
                end else begin
                    drop_inc    = 1'b1;
                    state_d     = eof_in ? IDLE : DROP;
                end
            end else begin
                case (state)
                    FWD: begin
                        val_d[sel_q] = 1'b1;
                        eof_d[sel_q] = eof_in;
                        err_d[sel_q] = err_in;
                        if (eof_in) state_d = IDLE;
                    end
                    DROP: begin
                        if (eof_in) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, port select and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= '0;
            val   <= '0;
            sof   <= '0;
            eof   <= '0;
            err   <= '0;
            abt   <= '0;
            dat   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            sel_q <= sel_d;
            val   <= val_d;
            sof   <= sof_d;
            eof   <= eof_d;
            err   <= err_d;
            abt   <= abt_d;
            busy  <= (state_d != IDLE);
            if (|val_d) dat <= dat_in;
        end
    end

    // Per-port metadata, captured with that port's sof and held until its next sof.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load_meta && sel_d == SW'(i)) meta[i] <= meta_in;
            end
        end
    end

`ifdef ETH_VLG_RX_DISP_STATS_EN
    // Saturating drop and abort counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            abt_cnt  <= '0;
        end else begin
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if ((|abt_d) && abt_cnt != 16'hFFFF)  abt_cnt  <= abt_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = '0;
    assign abt_cnt  = '0;
`endif

endmodule

// File: tb/tb_ipv4_vlg_rx_disp.sv
module tb_ipv4_vlg_rx_disp;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       proto_in;
    logic [31:0]      meta_in;
    logic [7:0]       dat_in;
    logic             val_in, sof_in, eof_in, err_in;
    logic [2:0][31:0] meta;
    logic [7:0]       dat;
    logic [2:0]       val, sof, eof, err, abt;
    logic             busy;
    logic [15:0]      drop_cnt, abt_cnt;

    int               checks = 0;
    int               errors = 0;
    logic [15:0]      exp_drop = 16'd0;
    logic [15:0]      exp_abt  = 16'd0;

    ipv4_vlg_rx_disp #(.N(3), .W(32), .PROTO({8'd6, 8'd17, 8'd1})) dut (
        .clk(clk), .rst(rst), .proto_in(proto_in), .meta_in(meta_in), .dat_in(dat_in),
        .val_in(val_in), .sof_in(sof_in), .eof_in(eof_in), .err_in(err_in),
        .meta(meta), .dat(dat), .val(val), .sof(sof), .eof(eof), .err(err), .abt(abt),
        .busy(busy), .drop_cnt(drop_cnt), .abt_cnt(abt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle; outputs are sampled 1 time unit after the capturing edge.
    task automatic drv(input bit v, input bit s, input bit e, input bit er,
                       input logic [7:0] d, input logic [7:0] p, input logic [31:0] m);
        val_in = v; sof_in = s; eof_in = e; err_in = er;
        dat_in = d; proto_in = p; meta_in = m;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] ev, input logic [2:0] es,
                              input logic [2:0] ee, input logic [2:0] er, input logic [2:0] ea,
                              input logic [7:0] ed);
        chk({tag, ".val"}, 96'(val), 96'(ev));
        chk({tag, ".sof"}, 96'(sof), 96'(es));
        chk({tag, ".eof"}, 96'(eof), 96'(ee));
        chk({tag, ".err"}, 96'(err), 96'(er));
        chk({tag, ".abt"}, 96'(abt), 96'(ea));
        if (ev != 3'b000) chk({tag, ".dat"}, 96'(dat), 96'(ed));
    endtask

    task automatic note_drop();
`ifdef ETH_VLG_RX_DISP_STATS_EN
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
    endtask

    task automatic note_abt();
`ifdef ETH_VLG_RX_DISP_STATS_EN
        if (exp_abt != 16'hFFFF) exp_abt = exp_abt + 16'd1;
`endif
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".drop_cnt"}, 96'(drop_cnt), 96'(exp_drop));
        chk({tag, ".abt_cnt"},  96'(abt_cnt),  96'(exp_abt));
    endtask

    logic [7:0]  bproto [3];
    int          bport  [3];
    bit          gv [9];
    bit          gs [9];
    bit          ge [9];

    initial begin
        rst = 1'b1;
        val_in = 0; sof_in = 0; eof_in = 0; err_in = 0;
        dat_in = 0; proto_in = 0; meta_in = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        expect_out("rst", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        chk("rst.dat", 96'(dat), 96'h0);
        chk("rst.meta", 96'(meta), 96'h0);
        chk("rst.busy", 96'(busy), 96'h0);
        chk_cnt("rst");
        rst = 1'b0;

        // Single-port routing: proto 6 goes to port 2
        for (int i = 0; i < 20; i++) begin
            drv(1, i == 0, i == 19, 0, 8'h10 + 8'(i), 8'd6, 32'hA5A5_0001);
            expect_out("t1", 3'b100, (i == 0) ? 3'b100 : 3'b000, (i == 19) ? 3'b100 : 3'b000,
                       3'b000, 3'b000, 8'h10 + 8'(i));
            if (i == 0) chk("t1.meta", 96'(meta), {32'hA5A5_0001, 64'h0});
            if (i == 10) chk("t1.busy", 96'(busy), 96'h1);
        end
        drv(0, 0, 0, 0, 8'h00, 8'd0, 32'h0);
        chk("t1.busy_end", 96'(busy), 96'h0);
        expect_out("t1.idle", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);

        // Back-to-back 17, 1, 6 with no idle cycles
        bproto[0] = 8'd17; bproto[1] = 8'd1; bproto[2] = 8'd6;
        bport[0]  = 1;     bport[1]  = 0;    bport[2]  = 2;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                drv(1, i == 0, i == 3, 0, 8'h20 + 8'(k * 4 + i), bproto[k], 32'hB000_0000 + 32'(k));
                expect_out("t2", 3'(1 << bport[k]), (i == 0) ? 3'(1 << bport[k]) : 3'b000,
                           (i == 3) ? 3'(1 << bport[k]) : 3'b000, 3'b000, 3'b000,
                           8'h20 + 8'(k * 4 + i));
            end
        end
        chk("t2.meta", 96'(meta), {32'hB000_0002, 32'hB000_0000, 32'hB000_0001});
        // Single-byte packet, sof and eof together
        drv(1, 1, 1, 0, 8'h5A, 8'd1, 32'hB000_0010);
        expect_out("t2.single", 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 8'h5A);
        drv(0, 0, 0, 0, 8'h00, 8'd0, 32'h0);
        chk("t2.busy", 96'(busy), 96'h0);
        // Byte without sof while idle is discarded
        drv(1, 0, 0, 0, 8'h77, 8'd6, 32'h0);
        expect_out("t2.stray", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);

        // Unmatched protocol: dropped
        for (int i = 0; i < 10; i++) begin
            drv(1, i == 0, i == 9, 0, 8'h30 + 8'(i), 8'd50, 32'hDEAD_0000);
            if (i == 0) note_drop();
            expect_out("t3", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
            if (i == 4) chk("t3.busy", 96'(busy), 96'h1);
        end
        drv(0, 0, 0, 0, 8'h00, 8'd0, 32'h0);
        chk("t3.busy_end", 96'(busy), 96'h0);
        chk_cnt("t3");
        // err_in on the sof byte drops a matching packet
        for (int i = 0; i < 3; i++) begin
            drv(1, i == 0, i == 2, i == 0, 8'h40 + 8'(i), 8'd17, 32'hDEAD_0001);
            if (i == 0) note_drop();
            expect_out("t3.errsof", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        end
        chk("t3.meta_kept", 96'(meta), {32'hB000_0002, 32'hB000_0000, 32'hB000_0010});
        chk_cnt("t3.errsof");

        // Abort on same port: sof reasserted at byte 5
        for (int i = 0; i < 10; i++) begin
            drv(1, i == 0 || i == 5, i == 9, 0, 8'h50 + 8'(i), 8'd17,
                (i < 5) ? 32'hC000_0001 : 32'hC000_0002);
            if (i == 5) note_abt();
            expect_out("t4", 3'b010, (i == 0 || i == 5) ? 3'b010 : 3'b000,
                       (i == 9) ? 3'b010 : 3'b000, 3'b000, (i == 5) ? 3'b010 : 3'b000,
                       8'h50 + 8'(i));
            if (i == 5) chk("t4.meta", 96'(meta[1]), 96'(32'hC000_0002));
        end
        chk_cnt("t4");
        // Cross-port abort into DROP, then sof from DROP into a forwarded packet
        drv(1, 1, 0, 0, 8'h60, 8'd6, 32'hC000_0003);
        expect_out("t4.x0", 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 8'h60);
        drv(1, 0, 0, 0, 8'h61, 8'd0, 32'h0);
        expect_out("t4.x1", 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 8'h61);
        drv(1, 1, 0, 0, 8'h62, 8'd50, 32'h0);
        note_abt(); note_drop();
        expect_out("t4.x2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 8'h00);
        drv(1, 0, 0, 0, 8'h63, 8'd0, 32'h0);
        expect_out("t4.x3", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        drv(1, 1, 1, 0, 8'h64, 8'd1, 32'hC000_0004);
        expect_out("t4.x4", 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 8'h64);
        drv(0, 0, 0, 0, 8'h00, 8'd0, 32'h0);
        chk("t4.busy", 96'(busy), 96'h0);
        chk_cnt("t4.x");

        // err_in on byte 3 of a forwarded packet
        for (int i = 0; i < 6; i++) begin
            drv(1, i == 0, i == 5, i == 3, 8'h70 + 8'(i), 8'd1, 32'hE000_0001);
            expect_out("t5.err", 3'b001, (i == 0) ? 3'b001 : 3'b000, (i == 5) ? 3'b001 : 3'b000,
                       (i == 3) ? 3'b001 : 3'b000, 3'b000, 8'h70 + 8'(i));
        end
        // Gaps in val_in, including sof/eof asserted while val_in is low
        gv = '{1, 0, 1, 0, 0, 1, 1, 0, 1};
        gs = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        ge = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        begin
            logic [7:0] nb;
            nb = 8'h80;
            for (int i = 0; i < 9; i++) begin
                drv(gv[i], gs[i], ge[i], 0, gv[i] ? nb : 8'hEE, 8'd6, 32'hE000_0002);
                expect_out("t5.gap", gv[i] ? 3'b100 : 3'b000, (i == 0) ? 3'b100 : 3'b000,
                           (i == 8) ? 3'b100 : 3'b000, 3'b000, 3'b000, nb);
                if (gv[i]) nb = nb + 8'd1;
            end
        end
        drv(0, 0, 0, 0, 8'h00, 8'd0, 32'h0);
        chk("t5.busy", 96'(busy), 96'h0);

        // Reset mid-FWD: everything clears, no abort
        for (int i = 0; i < 3; i++) begin
            drv(1, i == 0, 0, 0, 8'h90 + 8'(i), 8'd17, 32'hF000_0001);
        end
        rst = 1'b1;
        drv(1, 0, 0, 0, 8'h93, 8'd0, 32'h0);
        expect_out("t6.rst", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        chk("t6.dat", 96'(dat), 96'h0);
        chk("t6.meta", 96'(meta), 96'h0);
        chk("t6.busy", 96'(busy), 96'h0);
        exp_drop = 16'd0; exp_abt = 16'd0;
        chk_cnt("t6.rst");
        rst = 1'b0;
        drv(1, 0, 1, 0, 8'h94, 8'd0, 32'h0);
        expect_out("t6.after", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        chk("t6.busy_after", 96'(busy), 96'h0);

`ifdef ETH_VLG_RX_DISP_STATS_EN
        // Drop counter saturation with single-byte unmatched packets
        for (int i = 0; i < 65540; i++) begin
            drv(1, 1, 1, 0, 8'h00, 8'd50, 32'h0);
            note_drop();
        end
        chk("t6.sat", 96'(drop_cnt), 96'(16'hFFFF));
        chk_cnt("t6.sat");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
